// File: rtl/alu_count_zeros_pipe.sv
// alu_count_zeros_pipe: two-stage pipelined bit-count unit for the integer ALU.
// Handles CLZ/CTZ and their word forms CLZW/CTZW. When ALU_COUNT_ZEROS_CPOP_EN
// is defined it also handles CPOP/CPOPW. Without the macro, op=2 returns 0 like
// the reserved op.
//   S1: conditions the operand (bit reversal, word masking) and encodes each
//       BLOCK_W-bit block into an all-zero flag plus a first-set-bit index.
//   S2: priority-combines the block codes into the final zero-extended count.
// Valid/ready on both sides, flush, and a pass-through tag.
module alu_count_zeros_pipe #(
    parameter int XLEN    = 64,
    parameter int BLOCK_W = 8,
    parameter int TAG_W   = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic             word_i,
    input  logic [XLEN-1:0]  data_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int NBLK  = XLEN / BLOCK_W;
    localparam int WBLK  = 32 / BLOCK_W;
    localparam int IDX_W = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int CNT_W = $clog2(XLEN) + 1;
`ifdef ALU_COUNT_ZEROS_CPOP_EN
    localparam int PC_W  = $clog2(BLOCK_W) + 1;
`endif

    typedef enum logic [1:0] {
        OP_CLZ  = 2'd0,
        OP_CTZ  = 2'd1,
        OP_CPOP = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_load, s2_load;

    // S1 drains into S2 whenever S2 is empty or is being emptied this cycle.
    assign s2_load = s1_valid_q & (~s2_valid_q | ready_i);
    // Flush does not gate ready_o; it only blocks the capture.
    assign ready_o = ~s1_valid_q | s2_load;
    assign s1_load = valid_i & ready_o;
    assign valid_o = s2_valid_q;

    // ------------------------------------------------------------------
    // Stage 1: operand conditioning and per-block encoding
    // ------------------------------------------------------------------
    logic [XLEN-1:0] cond;

    // Bit-reverse for CLZ so every search runs upward from bit 0.
    // Word mode uses only [31:0] and leaves the upper blocks zero.
    always_comb begin
        // NOTE: assign a default first so every path drives the signal and no latch is inferred.
        cond = '0;
        if (word_i) begin
            for (int i = 0; i < 32; i++) begin
                cond[i] = (op_i == OP_CLZ) ? data_i[31-i] : data_i[i];
            end
        end else begin
            for (int i = 0; i < XLEN; i++) begin
                cond[i] = (op_i == OP_CLZ) ? data_i[XLEN-1-i] : data_i[i];
            end
        end
    end

    logic [NBLK-1:0]            blk_zero;
    logic [NBLK-1:0][IDX_W-1:0] blk_idx;

    // For each block: an all-zero flag and the index of its lowest set bit.
    always_comb begin
        for (int b = 0; b < NBLK; b++) begin
            blk_zero[b] = ~|cond[b*BLOCK_W +: BLOCK_W];
            blk_idx[b]  = '0;
            for (int j = BLOCK_W - 1; j >= 0; j--) begin
                if (cond[b*BLOCK_W + j]) blk_idx[b] = IDX_W'(j);
            end
        end
    end

`ifdef ALU_COUNT_ZEROS_CPOP_EN
    logic [NBLK-1:0][PC_W-1:0] blk_pop;

    // Per-block population count. Bit reversal and word masking do not
    // change the number of set bits, so the conditioned operand is used.
    always_comb begin
        for (int b = 0; b < NBLK; b++) begin
            blk_pop[b] = '0;
            for (int j = 0; j < BLOCK_W; j++) begin
                blk_pop[b] = blk_pop[b] + PC_W'(cond[b*BLOCK_W + j]);
            end
        end
    end
`endif

    // S1 payload registers
    logic [NBLK-1:0]            s1_zero_q;
    logic [NBLK-1:0][IDX_W-1:0] s1_idx_q;
    op_e                        s1_op_q;
    logic                       s1_word_q;
    logic [TAG_W-1:0]           s1_tag_q;
`ifdef ALU_COUNT_ZEROS_CPOP_EN
    logic [NBLK-1:0][PC_W-1:0]  s1_pop_q;
`endif

    // Capture the block codes of an accepted op.
    // NOTE: payload has no reset; s1_valid_q qualifies it, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (s1_load) begin
            s1_zero_q <= blk_zero;
            s1_idx_q  <= blk_idx;
            s1_op_q   <= op_e'(op_i);
            s1_word_q <= word_i;
            s1_tag_q  <= tag_i;
`ifdef ALU_COUNT_ZEROS_CPOP_EN
            s1_pop_q  <= blk_pop;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: combine block codes into the count
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_d;
    logic [XLEN-1:0]  result_d;
`ifdef ALU_COUNT_ZEROS_CPOP_EN
    logic [CNT_W-1:0] pop_d;
`endif

    // Count = lowest non-zero block * BLOCK_W + its first-one index.
    // If no block is set, the count is the searched width.
    always_comb begin
        cnt_d = s1_word_q ? CNT_W'(32) : CNT_W'(XLEN);
        for (int b = NBLK - 1; b >= 0; b--) begin
            if ((!s1_word_q || b < WBLK) && !s1_zero_q[b]) begin
                cnt_d = CNT_W'(b * BLOCK_W) + CNT_W'(s1_idx_q[b]);
            end
        end
    end

`ifdef ALU_COUNT_ZEROS_CPOP_EN
    // Sum of the per-block popcounts. Upper blocks are already zero in word mode.
    always_comb begin
        pop_d = '0;
        for (int b = 0; b < NBLK; b++) begin
            pop_d = pop_d + CNT_W'(s1_pop_q[b]);
        end
    end
`endif

    // Select the result by op. Reserved ops yield zero.
    always_comb begin
        case (s1_op_q)
            OP_CLZ, OP_CTZ: result_d = XLEN'(cnt_d);
`ifdef ALU_COUNT_ZEROS_CPOP_EN
            OP_CPOP:        result_d = XLEN'(pop_d);
`endif
            default:        result_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Valid bookkeeping: flush beats loads, reset clears everything
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_load)      s1_valid_d = 1'b1;
            else if (s2_load) s1_valid_d = 1'b0;
            if (s2_load)      s2_valid_d = 1'b1;
            else if (ready_i) s2_valid_d = 1'b0;
        end
    end

    // Pipeline valid flags
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // S2 output registers. They hold while the result is stalled.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            result_o <= '0;
            tag_o    <= '0;
        end else if (s2_load) begin
            result_o <= result_d;
            tag_o    <= s1_tag_q;
        end
    end

endmodule
